// File: rtl/riscv_pkg.sv
// Shared RV32I front-end types: XLEN, the canonical NOP, and the fetch entry.
// Provides word_align() for forcing byte addresses onto 4-byte boundaries.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(
    input logic [XLEN-1:0] a
  );
    return a & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch bus bundle: imem request/response plus the instruction handshake.
// master = fetch unit side; slave = memory + consumer side.
interface instr_fetch_unit_if;
  import riscv_pkg::*;

  logic            ireq;
  logic [XLEN-1:0] iaddr;
  logic            ivalid;
  logic [XLEN-1:0] idata;

  logic            instr_valid;
  logic            instr_ready;
  logic [XLEN-1:0] instr_data;
  logic [XLEN-1:0] instr_pc;

  modport master (
    output ireq, iaddr,
    input  ivalid, idata,
    output instr_valid, instr_data, instr_pc,
    input  instr_ready
  );

  modport slave (
    input  ireq, iaddr,
    output ivalid, idata,
    input  instr_valid, instr_data, instr_pc,
    output instr_ready
  );

endinterface

// File: rtl/instr_fetch_unit_fifo.sv
// fetch_fifo: registered prefetch FIFO of fetch_entry_t, no bypass.
// Ports: clk, reset, push/din, pop, flush, head, count, empty, full.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  fetch_entry_t                 din,
  output fetch_entry_t                 head,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output logic                         full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  fetch_entry_t    mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && !full && !flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_unit.sv
// RV32I fetch front end: credit-limited imem requests, prefetch FIFO, redirect.
// Ports: clk, reset, redirect, redirect_pc, bus (imem + instr handshake).
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              DEPTH    = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 redirect,
  input  logic [XLEN-1:0]      redirect_pc,
  instr_fetch_unit_if.master   bus
);

  localparam int            CW    = $clog2(DEPTH+1);
  localparam logic [CW:0]   LIMIT = (CW+1)'(DEPTH);

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] resp_pc;
  logic [XLEN-1:0] target;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   discard;
  logic [CW-1:0]   fifo_count;
  logic [CW:0]     inflight;
  logic            issue;
  logic            accept;
  logic            push;
  logic            pop;
  logic            empty;
  logic            full;
  fetch_entry_t    head;
  fetch_entry_t    din;

  assign target   = word_align(redirect_pc);
  assign inflight = {1'b0, fifo_count} + {1'b0, outstanding};

  // Buffered plus in-flight words never exceed DEPTH, so a push can
  // never find the FIFO full.
  assign issue  = !reset && !redirect && (inflight < LIMIT);
  assign accept = bus.ivalid && (discard == '0);
  assign push   = accept && !redirect && !full;
  assign pop    = bus.instr_valid && bus.instr_ready;
  assign din    = '{pc: resp_pc, instr: bus.idata};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else if (redirect) begin
      fetch_pc    <= target;
      resp_pc     <= target;
      // Everything still in flight is stale; a response landing this
      // cycle is already being dropped.
      outstanding <= outstanding - CW'(bus.ivalid);
      discard     <= outstanding - CW'(bus.ivalid);
    end else begin
      if (issue)  fetch_pc <= fetch_pc + 32'd4;
      if (accept) resp_pc  <= resp_pc + 32'd4;
      outstanding <= outstanding + CW'(issue) - CW'(bus.ivalid);
      if (bus.ivalid && discard != '0) discard <= discard - CW'(1);
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .din   (din),
    .head  (head),
    .count (fifo_count),
    .empty (empty),
    .full  (full)
  );

  assign bus.ireq        = issue;
  assign bus.iaddr       = fetch_pc;
  assign bus.instr_valid = !empty;
  assign bus.instr_data  = empty ? NOP_INSTR : head.instr;
  assign bus.instr_pc    = empty ? '0 : head.pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit with a latency-L memory model
// and a scoreboard of expected {pc, instr} pairs.
module tb_instr_fetch_unit;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        redirect2;
  logic [31:0] redirect_pc2;

  always #5 clk = ~clk;

  instr_fetch_unit_if bus ();
  instr_fetch_unit_if bus2 ();

  instr_fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .bus         (bus)
  );

  instr_fetch_unit #(
    .RESET_PC (32'hFFFF_FFF8),
    .DEPTH    (4)
  ) u_wrap (
    .clk         (clk),
    .reset       (reset),
    .redirect    (redirect2),
    .redirect_pc (redirect_pc2),
    .bus         (bus2)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  req_t         mq[$];
  fetch_entry_t sb[$];
  int cyc, lat, passed, total, nreq;

  logic        l_ireq, l_valid, l_ivalid;
  logic [31:0] l_iaddr, l_pc, l_data;
  logic        w_ireq, w_valid;
  logic [31:0] w_iaddr, w_pc, w_data;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
  endfunction

  task automatic tick();
    fetch_entry_t exp;
    @(negedge clk);
    l_ireq   = bus.ireq;
    l_iaddr  = bus.iaddr;
    l_valid  = bus.instr_valid;
    l_pc     = bus.instr_pc;
    l_data   = bus.instr_data;
    l_ivalid = bus.ivalid;
    w_ireq   = bus2.ireq;
    w_iaddr  = bus2.iaddr;
    w_valid  = bus2.instr_valid;
    w_pc     = bus2.instr_pc;
    w_data   = bus2.instr_data;
    if (l_ireq) begin
      mq.push_back('{addr: l_iaddr, due: cyc + lat});
      sb.push_back('{pc: l_iaddr, instr: mem_word(l_iaddr)});
      nreq++;
    end
    if (redirect) begin
      sb.delete();
    end else if (l_valid && bus.instr_ready) begin
      total++;
      if (sb.size() == 0) begin
        $display("FAIL pop_order: got pc=%h, nothing expected", l_pc);
      end else begin
        exp = sb.pop_front();
        if (l_pc !== exp.pc || l_data !== exp.instr)
          $display("FAIL pop_order: got pc=%h data=%h, want pc=%h data=%h",
                   l_pc, l_data, exp.pc, exp.instr);
        else passed++;
      end
    end
    if (!l_valid) begin
      total++;
      if (l_pc !== '0 || l_data !== NOP_INSTR)
        $display("FAIL empty_out: got pc=%h data=%h, want 0/%h",
                 l_pc, l_data, NOP_INSTR);
      else passed++;
    end
    @(posedge clk);
    #1;
    cyc++;
    redirect = 1'b0;
    if (mq.size() != 0 && mq[0].due == cyc) begin
      bus.ivalid = 1'b1;
      bus.idata  = mem_word(mq[0].addr);
      void'(mq.pop_front());
    end else begin
      bus.ivalid = 1'b0;
      bus.idata  = '0;
    end
    bus2.ivalid = w_ireq;
    bus2.idata  = mem_word(w_iaddr);
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    redirect    = 1'b0;
    bus.ivalid  = 1'b0;
    bus.idata   = '0;
    bus2.ivalid = 1'b0;
    bus2.idata  = '0;
    mq.delete();
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    cyc   = 0;
    nreq  = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++;
    if (bus.ireq !== 1'b0) $display("FAIL rst_ireq: got %b want 0", bus.ireq);
    else passed++;
    total++;
    if (bus.iaddr !== 32'h0) $display("FAIL rst_iaddr: got %h want 0", bus.iaddr);
    else passed++;
    total++;
    if (bus.instr_valid !== 1'b0)
      $display("FAIL rst_valid: got %b want 0", bus.instr_valid);
    else passed++;
    total++;
    if (bus.instr_data !== 32'h13)
      $display("FAIL rst_data: got %h want 13", bus.instr_data);
    else passed++;
    total++;
    if (bus.instr_pc !== 32'h0) $display("FAIL rst_pc: got %h want 0", bus.instr_pc);
    else passed++;
    total++;
    if (bus2.iaddr !== 32'hFFFF_FFF8)
      $display("FAIL rst_iaddr2: got %h want fffffff8", bus2.iaddr);
    else passed++;
  endtask

  task automatic test_cold_start();
    logic [31:0] ea;
    int fr, fv;
    do_reset();
    lat = 1;
    bus.instr_ready = 1'b1;
    ea = '0;
    fr = -1;
    fv = -1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (l_ireq && fr < 0) fr = i;
      if (fv >= 0) begin
        total++;
        if (!l_valid) $display("FAIL stream_gap: got valid=0 at cycle %0d want 1", i);
        else passed++;
      end
      if (l_valid && fv < 0) begin
        fv = i;
        total++;
        if (l_pc !== 32'h0) $display("FAIL first_pc: got %h want 0", l_pc);
        else passed++;
      end
      total++;
      if (l_ireq !== 1'b1 || l_iaddr !== ea)
        $display("FAIL iaddr_seq: got ireq=%b addr=%h want 1/%h", l_ireq, l_iaddr, ea);
      else passed++;
      ea += 32'd4;
    end
    total++;
    if (fr < 0 || fv - fr != 2)
      $display("FAIL first_latency: got req@%0d valid@%0d want gap 2", fr, fv);
    else passed++;
  endtask

  task automatic test_backpressure();
    int found;
    do_reset();
    lat = 1;
    bus.instr_ready = 1'b0;
    repeat (8) tick();
    total++;
    if (nreq != 4) $display("FAIL bp_reqs: got %0d want 4", nreq);
    else passed++;
    total++;
    if (l_ireq !== 1'b0) $display("FAIL bp_ireq: got %b want 0", l_ireq);
    else passed++;
    total++;
    if (l_valid !== 1'b1 || l_pc !== 32'h0)
      $display("FAIL bp_head: got valid=%b pc=%h want 1/0", l_valid, l_pc);
    else passed++;
    bus.instr_ready = 1'b1;
    found = 0;
    for (int i = 0; i < 8 && found == 0; i++) begin
      tick();
      if (l_ireq) begin
        found = 1;
        total++;
        if (l_iaddr !== 32'h10) $display("FAIL bp_resume: got %h want 10", l_iaddr);
        else passed++;
      end
    end
    if (found == 0) begin
      total++;
      $display("FAIL bp_resume: got no ireq want addr 10");
    end
    repeat (6) tick();
  endtask

  task automatic test_redirect();
    int found;
    do_reset();
    lat = 3;
    bus.instr_ready = 1'b1;
    tick();
    tick();
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0103;
    tick();
    total++;
    if (l_ireq !== 1'b0) $display("FAIL rd_ireq: got %b want 0", l_ireq);
    else passed++;
    tick();
    total++;
    if (l_ireq !== 1'b1 || l_iaddr !== 32'h100)
      $display("FAIL rd_addr: got ireq=%b addr=%h want 1/100", l_ireq, l_iaddr);
    else passed++;
    found = 0;
    for (int i = 0; i < 12 && found == 0; i++) begin
      tick();
      if (l_valid) begin
        found = 1;
        total++;
        if (l_pc !== 32'h100) $display("FAIL rd_first_pc: got %h want 100", l_pc);
        else passed++;
      end
    end
    if (found == 0) begin
      total++;
      $display("FAIL rd_first_pc: got no valid want pc 100");
    end
    repeat (4) tick();
  endtask

  task automatic test_redirect_collide();
    int found;
    do_reset();
    lat = 2;
    bus.instr_ready = 1'b1;
    repeat (3) tick();
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0200;
    tick();
    total++;
    if (l_valid !== 1'b1 || l_ivalid !== 1'b1)
      $display("FAIL col_setup: got valid=%b ivalid=%b want 1/1", l_valid, l_ivalid);
    else passed++;
    tick();
    total++;
    if (l_valid !== 1'b0) $display("FAIL col_flush: got valid=%b want 0", l_valid);
    else passed++;
    tick();
    total++;
    if (l_valid !== 1'b0) $display("FAIL col_stale: got valid=%b want 0", l_valid);
    else passed++;
    found = 0;
    for (int i = 0; i < 10 && found == 0; i++) begin
      tick();
      if (l_valid) begin
        found = 1;
        total++;
        if (l_pc !== 32'h200) $display("FAIL col_first_pc: got %h want 200", l_pc);
        else passed++;
      end
    end
    if (found == 0) begin
      total++;
      $display("FAIL col_first_pc: got no valid want pc 200");
    end
    repeat (4) tick();
  endtask

  task automatic test_wrap();
    logic [31:0] exp_w [3];
    int na, np;
    exp_w[0] = 32'hFFFF_FFF8;
    exp_w[1] = 32'hFFFF_FFFC;
    exp_w[2] = 32'h0000_0000;
    do_reset();
    lat = 1;
    na = 0;
    np = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (w_ireq && na < 3) begin
        total++;
        if (w_iaddr !== exp_w[na])
          $display("FAIL wrap_addr: got %h want %h", w_iaddr, exp_w[na]);
        else passed++;
        na++;
      end
      if (w_valid && np < 3) begin
        total++;
        if (w_pc !== exp_w[np] || w_data !== mem_word(exp_w[np]))
          $display("FAIL wrap_pc: got pc=%h data=%h want %h/%h",
                   w_pc, w_data, exp_w[np], mem_word(exp_w[np]));
        else passed++;
        np++;
      end
    end
    total++;
    if (na != 3 || np != 3) $display("FAIL wrap_count: got %0d/%0d want 3/3", na, np);
    else passed++;
  endtask

  task automatic test_async_reset();
    int found;
    do_reset();
    lat = 1;
    bus.instr_ready = 1'b1;
    repeat (6) tick();
    #2;
    reset       = 1'b1;
    bus.ivalid  = 1'b0;
    bus2.ivalid = 1'b0;
    mq.delete();
    sb.delete();
    #1;
    total++;
    if (bus.ireq !== 1'b0) $display("FAIL ar_ireq: got %b want 0", bus.ireq);
    else passed++;
    total++;
    if (bus.instr_valid !== 1'b0)
      $display("FAIL ar_valid: got %b want 0", bus.instr_valid);
    else passed++;
    total++;
    if (bus.instr_data !== 32'h13)
      $display("FAIL ar_data: got %h want 13", bus.instr_data);
    else passed++;
    total++;
    if (bus.iaddr !== 32'h0) $display("FAIL ar_iaddr: got %h want 0", bus.iaddr);
    else passed++;
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc   = 0;
    nreq  = 0;
    tick();
    total++;
    if (l_ireq !== 1'b1 || l_iaddr !== 32'h0)
      $display("FAIL ar_restart: got ireq=%b addr=%h want 1/0", l_ireq, l_iaddr);
    else passed++;
    found = 0;
    for (int i = 0; i < 6 && found == 0; i++) begin
      tick();
      if (l_valid) begin
        found = 1;
        total++;
        if (l_pc !== 32'h0) $display("FAIL ar_first_pc: got %h want 0", l_pc);
        else passed++;
      end
    end
    if (found == 0) begin
      total++;
      $display("FAIL ar_first_pc: got no valid want pc 0");
    end
    repeat (4) tick();
  endtask

  initial begin
    passed           = 0;
    total            = 0;
    cyc              = 0;
    nreq             = 0;
    lat              = 1;
    redirect2        = 1'b0;
    redirect_pc2     = '0;
    bus.ivalid       = 1'b0;
    bus.idata        = '0;
    bus.instr_ready  = 1'b0;
    bus2.ivalid      = 1'b0;
    bus2.idata       = '0;
    bus2.instr_ready = 1'b1;
    test_reset();
    test_cold_start();
    test_backpressure();
    test_redirect();
    test_redirect_collide();
    test_wrap();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
